// File: rtl/pc_sequencer.sv
// Next-PC controller for the single-cycle core: sequential/branch/jump/mret selection,
// trap and ebreak-halt sequencing, EPC/MCAUSE capture and retired-instruction counting.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] MTVEC     = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret,
    input  logic        resume,
    output logic [31:0] pc_next,
    output logic [31:0] epc,
    output logic [3:0]  mcause,
    output logic        trap_active,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_EBREAK   = 4'd3;
    localparam logic [3:0] CAUSE_ECALL    = 4'd11;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] epc_r;
    logic [31:0] epc_s;
    logic [3:0]  mcause_r;
    logic [3:0]  mcause_s;
    logic [31:0] instret_r;
    logic        retire_s;
    logic [31:0] pc_next_s;

    // Next-PC selection, next state and trap-record updates
    always_comb begin
        state_s   = state_r;
        epc_s     = epc_r;
        mcause_s  = mcause_r;
        retire_s  = 1'b0;
        pc_next_s = pc;
        if (rst) begin
            pc_next_s = RESET_VEC;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (stall) begin
                        pc_next_s = pc;
                    end else if (ecall) begin
                        epc_s    = pc;
                        mcause_s = CAUSE_ECALL;
                        state_s  = ST_TRAP;
                    end else if (ebreak) begin
                        mcause_s = CAUSE_EBREAK;
                        state_s  = ST_HALT;
                    end else if (mret) begin
                        pc_next_s = epc_r;
                        retire_s  = 1'b1;
                    end else if (jump) begin
                        // A misaligned target traps instead of redirecting
                        if (jump_target[1:0] != 2'b00) begin
                            epc_s    = pc;
                            mcause_s = CAUSE_MISALIGN;
                            state_s  = ST_TRAP;
                        end else begin
                            pc_next_s = jump_target;
                            retire_s  = 1'b1;
                        end
                    end else if (branch_taken) begin
                        if (branch_target[1:0] != 2'b00) begin
                            epc_s    = pc;
                            mcause_s = CAUSE_MISALIGN;
                            state_s  = ST_TRAP;
                        end else begin
                            pc_next_s = branch_target;
                            retire_s  = 1'b1;
                        end
                    end else begin
                        pc_next_s = pc + 32'd4;
                        retire_s  = 1'b1;
                    end
                end
                ST_TRAP: begin
                    pc_next_s = MTVEC;
                    state_s   = ST_RUN;
                end
                ST_HALT: begin
                    if (resume) begin
                        pc_next_s = pc + 32'd4;
                        retire_s  = 1'b1;
                        state_s   = ST_RUN;
                    end else begin
                        pc_next_s = pc;
                    end
                end
                default: begin
                    pc_next_s = pc;
                    state_s   = ST_RUN;
                end
            endcase
        end
    end

    // State, trap record and retire counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RUN;
            epc_r     <= 32'd0;
            mcause_r  <= 4'd0;
            instret_r <= 32'd0;
        end else begin
            state_r  <= state_s;
            epc_r    <= epc_s;
            mcause_r <= mcause_s;
            if (retire_s) begin
                instret_r <= instret_r + 32'd1;
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign pc_next     = pc_next_s;
    assign epc         = epc_r;
    assign mcause      = mcause_r;
    assign instret     = instret_r;
    assign trap_active = (state_r == ST_TRAP);
    assign halted      = (state_r == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random traffic,
// all compared against a behavioural next-PC/trap model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] MT = 32'h0000_0100;
    localparam int RUN = 0, TRAP = 1, HALT = 2;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump, ecall, ebreak, mret, resume;
    logic [31:0] pc, branch_target, jump_target;
    logic [31:0] pc_next, epc, instret;
    logic [3:0]  mcause;
    logic        trap_active, halted;

    int          total = 0;
    int          bad   = 0;

    int          m_mode, n_mode;
    logic [31:0] m_epc, n_epc, m_inst, n_inst, e_pc;
    logic [3:0]  m_mc, n_mc;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VEC(RV), .MTVEC(MT)) dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .ecall(ecall), .ebreak(ebreak), .mret(mret), .resume(resume),
        .pc_next(pc_next), .epc(epc), .mcause(mcause),
        .trap_active(trap_active), .halted(halted), .instret(instret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: decide this cycle's next PC and the state after the coming edge
    task automatic model_calc();
        logic [31:0] tgt;
        logic        redirect;
        n_mode = m_mode; n_epc = m_epc; n_mc = m_mc; n_inst = m_inst;
        e_pc   = pc;
        if (rst) begin
            e_pc = RV; n_mode = RUN; n_epc = 32'd0; n_mc = 4'd0; n_inst = 32'd0;
        end else if (m_mode == TRAP) begin
            e_pc = MT; n_mode = RUN;
        end else if (m_mode == HALT) begin
            if (resume) begin
                e_pc = pc + 32'd4; n_inst = m_inst + 32'd1; n_mode = RUN;
            end
        end else begin
            redirect = jump || branch_taken;
            tgt      = jump ? jump_target : branch_target;
            if (stall) begin
                e_pc = pc;
            end else if (ecall) begin
                n_epc = pc; n_mc = 4'd11; n_mode = TRAP;
            end else if (ebreak) begin
                n_mc = 4'd3; n_mode = HALT;
            end else if (mret) begin
                e_pc = m_epc; n_inst = m_inst + 32'd1;
            end else if (redirect && (tgt % 32'd4 != 32'd0)) begin
                n_epc = pc; n_mc = 4'd0; n_mode = TRAP;
            end else if (redirect) begin
                e_pc = tgt; n_inst = m_inst + 32'd1;
            end else begin
                e_pc = pc + 32'd4; n_inst = m_inst + 32'd1;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] p, input logic st,
                         input logic bt, input logic [31:0] btg,
                         input logic j, input logic [31:0] jtg,
                         input logic ec, input logic eb, input logic mr, input logic rs);
        rst = r; pc = p; stall = st; branch_taken = bt; branch_target = btg;
        jump = j; jump_target = jtg; ecall = ec; ebreak = eb; mret = mr; resume = rs;
        #1;
        model_calc();
        check("pc_next", pc_next, e_pc);
        check("trap_active", {31'd0, trap_active}, (m_mode == TRAP) ? 32'd1 : 32'd0);
        check("halted", {31'd0, halted}, (m_mode == HALT) ? 32'd1 : 32'd0);
        check("epc", epc, m_epc);
        check("mcause", {28'd0, mcause}, {28'd0, m_mc});
        check("instret", instret, m_inst);
    endtask

    task automatic tick();
        @(posedge clk);
        m_mode = n_mode; m_epc = n_epc; m_mc = n_mc; m_inst = n_inst;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] p);
        drive(1'b0, p, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rp, rbt, rjt;
        rst = 1'b1; pc = 32'd0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        jump = 1'b0; jump_target = 32'd0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; resume = 1'b0;
        @(posedge clk);
        m_mode = RUN; m_epc = 32'd0; m_mc = 4'd0; m_inst = 32'd0;
        @(negedge clk);

        // T1 reset with random inputs, then first sequential step
        drive(1'b1, $urandom, 1'b0, 1'b1, $urandom, 1'b1, $urandom, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t1_reset_vec", pc_next, 32'h0);
        tick();
        idle(32'h0);
        check("t1_seq", pc_next, 32'h4);
        tick();
        idle(32'h4);
        check("t1_instret", instret, 32'd1);

        // T2 jump beats branch; sequential wrap
        drive(1'b0, 32'h40, 1'b0, 1'b1, 32'h60, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_jump", pc_next, 32'h80);
        tick();
        idle(32'hFFFF_FFFC);
        check("t2_wrap", pc_next, 32'h0);
        check("t2_no_trap", {31'd0, trap_active}, 32'd0);
        tick();

        // T3 misaligned branch target
        drive(1'b0, 32'h20, 1'b0, 1'b1, 32'h22, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_hold", pc_next, 32'h20);
        tick();
        drive(1'b0, 32'h20, 1'b1, 1'b1, 32'h22, 1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t3_epc", epc, 32'h20);
        check("t3_mcause", {28'd0, mcause}, 32'd0);
        check("t3_mtvec", pc_next, 32'h100);
        tick();

        // T4 ecall then mret
        drive(1'b0, 32'h30, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle(32'h30);
        check("t4_mtvec", pc_next, 32'h100);
        check("t4_cause", {28'd0, mcause}, 32'd11);
        tick();
        idle(32'h100);
        tick();
        drive(1'b0, 32'h104, 1'b0, 1'b0, 32'd0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_mret", pc_next, 32'h30);
        tick();

        // T5 ebreak halt, five held cycles, then resume
        drive(1'b0, 32'h50, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h50, 1'($urandom_range(0, 1)), 1'b1, 32'h90, 1'b1, 32'h94,
                  1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
            check("t5_hold", pc_next, 32'h50);
            tick();
        end
        drive(1'b0, 32'h50, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_resume", pc_next, 32'h54);
        tick();
        idle(32'h54);
        check("t5_unhalted", {31'd0, halted}, 32'd0);
        tick();

        // T6 reset inside TRAP and HALT, then stall
        drive(1'b0, 32'h70, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h70, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle(32'h0);
        check("t6_trap_epc", epc, 32'h0);
        tick();
        drive(1'b0, 32'h4, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_stall", pc_next, 32'h0);
        check("t6_mcause", {28'd0, mcause}, 32'd0);
        tick();
        idle(32'h0);
        check("t6_instret", instret, 32'd0);
        tick();

        // Random traffic with the bench acting as the PC register
        rp = 32'h0;
        for (int i = 0; i < 800; i++) begin
            rbt = $urandom;
            rjt = $urandom;
            if ($urandom_range(0, 3) != 0) rbt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rjt[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rp = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if ($urandom_range(0, 31) == 0) rp = 32'hFFFF_FFFC;
            drive(1'($urandom_range(0, 39) == 0), rp,
                  1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) == 0), rbt,
                  1'($urandom_range(0, 5) == 0), rjt,
                  1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 3) == 0));
            rp = e_pc;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
